// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: run control, program-memory read bus and decoder output.
// The fetch stage drives through master; memory, execute and decoder sit on slave.
interface instr_fetch_if #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16
);
    logic                   EN;
    logic                   JMP;
    logic [PC_WIDTH-1:0]    JMP_ADDR;
    logic                   STALL;
    logic [PC_WIDTH-1:0]    PM_ADDR;
    logic                   PM_RE;
    logic [INSTR_WIDTH-1:0] PM_RDATA;
    logic [INSTR_WIDTH-1:0] INSTR;
    logic                   ID_CE;
    logic [PC_WIDTH-1:0]    PC;
    logic                   HALTED;

    modport master (
        input  EN, JMP, JMP_ADDR, STALL, PM_RDATA,
        output PM_ADDR, PM_RE, INSTR, ID_CE, PC, HALTED
    );

    modport slave (
        output EN, JMP, JMP_ADDR, STALL, PM_RDATA,
        input  PM_ADDR, PM_RE, INSTR, ID_CE, PC, HALTED
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, synchronous program-memory reads, registered
// issue to the decoder with stall, redirect and HALT handling.
module instr_fetch #(
    parameter int         PC_WIDTH    = 8,
    parameter int         INSTR_WIDTH = 16,
    parameter logic [3:0] HALT_OPCODE = 4'hF
) (
    input  logic          CLK,
    input  logic          RST,
    instr_fetch_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ISSUE,
        S_HALT
    } state_e;

    state_e                 state_q;
    logic [PC_WIDTH-1:0]    fetch_pc_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [PC_WIDTH-1:0]    pc_q;
    logic                   id_ce_q;
    logic                   halted_q;
    logic [3:0]             op_code;
    state_e                 resume_st;

    assign op_code   = instr_q[INSTR_WIDTH-1 -: 4];
    assign resume_st = bus.EN ? S_REQ : S_IDLE;

    assign bus.PM_RE   = (state_q == S_REQ);
    assign bus.PM_ADDR = fetch_pc_q;
    assign bus.INSTR   = instr_q;
    assign bus.ID_CE   = id_ce_q;
    assign bus.PC      = pc_q;
    assign bus.HALTED  = halted_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= '0;
            instr_q    <= '0;
            pc_q       <= '0;
            id_ce_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            if (bus.JMP) begin
                fetch_pc_q <= bus.JMP_ADDR;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (bus.EN) begin
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    state_q <= bus.JMP ? resume_st : S_WAIT;
                end
                S_WAIT: begin
                    // A redirect here drops the returning word unseen
                    if (bus.JMP) begin
                        state_q <= resume_st;
                    end else begin
                        instr_q    <= bus.PM_RDATA;
                        pc_q       <= fetch_pc_q;
                        fetch_pc_q <= fetch_pc_q + 1'b1;
                        id_ce_q    <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.JMP) begin
                        id_ce_q <= 1'b0;
                        state_q <= resume_st;
                    end else if (!bus.STALL) begin
                        id_ce_q <= 1'b0;
                        if (op_code == HALT_OPCODE) begin
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end else begin
                            state_q <= resume_st;
                        end
                    end
                end
                S_HALT: begin
                    if (bus.JMP && bus.EN) begin
                        halted_q <= 1'b0;
                        state_q  <= S_REQ;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
